operand_serializer: RTL

Parallel-to-serial front end for the bit-serial adder datapath. It accepts a pair of W-bit operands over a valid/ready handshake and streams them LSB-first, one bit per cycle, on `a`/`b` directly into the serial adder. Between words it drives GAP cycles of `a=b=0`; since 0+0 clears the adder's carry, each word is added independently without resetting the adder. A one-entry holding register accepts the next word while the current one is shifting, so a sustained producer incurs no extra bubble.

---
 rtl/operand_serializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/operand_serializer.sv
// Parallel-to-serial front end for the bit-serial adder: buffers one operand pair and streams
// it LSB-first, padding each word with GAP zero cycles so the adder's carry is flushed.
module operand_serializer #(
  parameter int unsigned W   = 16,
  parameter int unsigned GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         in_ready,
  output logic         a,
  output logic         b,
  output logic         bit_valid,
  output logic         first,
  output logic         last
);

  localparam int unsigned CntW = $clog2(W);
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [GapW-1:0] GapInit = GapW'(GAP);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic            hold_full_q, hold_full_d;
  logic [W-1:0]    sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            a_q, a_d, b_q, b_d;
  logic            bv_q, bv_d, first_q, first_d, last_q, last_d;
  logic            accept, load;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    bv_d    = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    load    = 1'b0;
    accept  = in_valid & ~hold_full_q;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d     = sh_a_q[0];
        b_d     = sh_b_q[0];
        bv_d    = 1'b1;
        first_d = (cnt_q == '0);
        last_d  = (cnt_q == CntLast);
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        cnt_d   = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GapInit;
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        gap_d = gap_q - GapOne;
        if (gap_q == GapOne) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A load always empties the holding register; accept can only happen while it is empty.
    if (load) begin
      sh_a_d = hold_a_q;
      sh_b_d = hold_b_q;
      cnt_d  = '0;
    end
    hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    hold_a_d    = accept ? in_a : hold_a_q;
    hold_b_d    = accept ? in_b : hold_b_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hold_full_q <= 1'b0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      bv_q        <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      hold_full_q <= hold_full_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      a_q         <= a_d;
      b_q         <= b_d;
      bv_q        <= bv_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign in_ready  = ~hold_full_q;
  assign a         = a_q;
  assign b         = b_q;
  assign bit_valid = bv_q;
  assign first     = first_q;
  assign last      = last_q;

endmodule
